// File: rtl/uart_rx_if.sv
// Serial receive bundle: line input, tick enable and received-frame outputs.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
    logic       rx;
    logic       s_tick;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;

    modport master (
        output rx, s_tick,
        input  dout, rx_done_tick, frame_err, parity_err
    );
    modport slave (
        input  rx, s_tick,
        output dout, rx_done_tick, frame_err, parity_err
    );
`else
    modport master (
        output rx, s_tick,
        input  dout, rx_done_tick, frame_err
    );
    modport slave (
        input  rx, s_tick,
        output dout, rx_done_tick, frame_err
    );
`endif
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampling, LSB first, DBIT data bits.
// Optional even-parity bit enabled with UART_RX_PARITY_EN.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic  clk,
    input  logic  reset,
    uart_rx_if.slave bus
);

    // Tick counter is widened only when a long stop period needs it.
    localparam int SW = (SB_TICK > 16) ? 5 : 4;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [SW-1:0] s_q, s_d;
    logic [2:0]    n_q, n_d;
    logic [7:0]    b_q, b_d;
    logic [7:0]    dout_q, dout_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;
    logic          rx_s;
    logic [7:0]    data_w;
`ifdef UART_RX_PARITY_EN
    logic          p_q, p_d;
    logic          perr_q, perr_d;
`endif

    assign rx_s   = sync2_q;
    // Data bits land in the top of b; right-align them.
    assign data_w = b_q >> (8 - DBIT);

    // Two-flop synchronizer; the line idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.rx;
            sync2_q <= sync1_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            p_q     <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            p_q     <= p_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // Next-state logic; everything holds between ticks.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
        p_d     = p_q;
        perr_d  = perr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (bus.s_tick) begin
                    if (s_q == SW'(7)) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (s_q == SW'(15)) begin
                        b_d = {rx_s, b_q[7:1]};
                        s_d = '0;
                        if (n_q == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bus.s_tick) begin
                    if (s_q == SW'(15)) begin
                        p_d     = rx_s;
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (bus.s_tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        dout_d  = data_w;
                        ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
                        perr_d  = (^data_w) ^ p_q;
`endif
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.dout         = dout_q;
    assign bus.rx_done_tick = done_q;
    assign bus.frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames at 16x ticks (one tick per 4 clk).
// Covers clean, framing-error, glitch, back-to-back and mid-frame reset.
module tb_uart_rx;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_rx_if bus();

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // One-clock s_tick every 4 clocks: 64 clocks per bit.
    logic [1:0] tdiv = 2'd0;
    always @(posedge clk) tdiv <= tdiv + 2'd1;
    assign bus.s_tick = (tdiv == 2'd3);

    int errors = 0;
    int checks = 0;

    // Record every completed frame, and catch pulses longer than one clk.
    int         done_cnt  = 0;
    int         dbl       = 0;
    logic       prev_done = 1'b0;
    logic [7:0] dq[$];
    logic       fq[$];
    always @(negedge clk) begin
        if (bus.rx_done_tick === 1'b1) begin
            done_cnt++;
            dq.push_back(bus.dout);
            fq.push_back(bus.frame_err);
            if (prev_done) dbl++;
        end
        prev_done = bus.rx_done_tick;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start bit, 8 data bits LSB first, optional parity, stop bit.
    // A low stop bit is held only past its sample point.
    task automatic send_frame(input logic [7:0] d, input logic pbit,
                              input logic stop);
        bus.rx = 1'b0;
        wait_clk(64);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            wait_clk(64);
        end
`ifdef UART_RX_PARITY_EN
        bus.rx = pbit;
        wait_clk(64);
`else
        if (pbit === 1'bx) wait_clk(0);
`endif
        if (stop) begin
            bus.rx = 1'b1;
            wait_clk(64);
        end else begin
            bus.rx = 1'b0;
            wait_clk(40);
            bus.rx = 1'b1;
            wait_clk(24);
        end
    endtask

    initial begin
        bus.rx = 1'b1;
        reset  = 1'b1;
        wait_clk(4);
        reset = 1'b0;
        wait_clk(2);
        chk("reset_dout", 32'(bus.dout), 32'h00);
        chk("reset_done", 32'(bus.rx_done_tick), 32'h0);
        chk("reset_ferr", 32'(bus.frame_err), 32'h0);
`ifdef UART_RX_PARITY_EN
        chk("reset_perr", 32'(bus.parity_err), 32'h0);
`endif
        wait_clk(20);

        // Clean 0x55.
        send_frame(8'h55, 1'b0, 1'b1);
        wait_clk(64);
        chk("f55_cnt", 32'(done_cnt), 32'd1);
        chk("f55_dout", 32'(bus.dout), 32'h55);
        chk("f55_ferr", 32'(bus.frame_err), 32'h0);

        // Low glitch of 4 ticks must be rejected.
        bus.rx = 1'b0;
        wait_clk(16);
        bus.rx = 1'b1;
        wait_clk(200);
        chk("glitch_cnt", 32'(done_cnt), 32'd1);
        chk("glitch_dout", 32'(bus.dout), 32'h55);

        // 0xA3 with a low stop bit.
        send_frame(8'hA3, 1'b0, 1'b0);
        wait_clk(100);
        chk("fA3_cnt", 32'(done_cnt), 32'd2);
        chk("fA3_dout", 32'(bus.dout), 32'hA3);
        chk("fA3_ferr", 32'(bus.frame_err), 32'h1);
        chk("fA3_ferr_q", 32'(fq[1]), 32'h1);

        // Clean 0x0F clears the framing error.
        send_frame(8'h0F, 1'b0, 1'b1);
        wait_clk(64);
        chk("f0F_cnt", 32'(done_cnt), 32'd3);
        chk("f0F_dout", 32'(bus.dout), 32'h0F);
        chk("f0F_ferr", 32'(bus.frame_err), 32'h0);

        // Back-to-back frames with no idle time.
        send_frame(8'hA3, 1'b0, 1'b1);
        send_frame(8'h0F, 1'b0, 1'b1);
        wait_clk(64);
        chk("b2b_cnt", 32'(done_cnt), 32'd5);
        chk("b2b_first", 32'(dq[3]), 32'hA3);
        chk("b2b_second", 32'(dq[4]), 32'h0F);

        // Reset in the middle of data bit 4 of 0xFF.
        bus.rx = 1'b0;
        wait_clk(64);
        bus.rx = 1'b1;
        wait_clk(64 * 4 + 32);
        reset = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        wait_clk(1);
        chk("rst_dout", 32'(bus.dout), 32'h00);
        chk("rst_done", 32'(bus.rx_done_tick), 32'h0);
        chk("rst_ferr", 32'(bus.frame_err), 32'h0);
        wait_clk(32 + 64 * 4 + 64);
        chk("rst_cnt", 32'(done_cnt), 32'd5);

        // Reception resumes cleanly.
        send_frame(8'h12, 1'b0, 1'b1);
        wait_clk(64);
        chk("f12_cnt", 32'(done_cnt), 32'd6);
        chk("f12_dout", 32'(bus.dout), 32'h12);
        chk("f12_ferr", 32'(bus.frame_err), 32'h0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight: even parity bit is 1.
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clk(64);
        chk("par1_dout", 32'(bus.dout), 32'h07);
        chk("par1_perr", 32'(bus.parity_err), 32'h0);
        send_frame(8'h07, 1'b0, 1'b1);
        wait_clk(64);
        chk("par0_perr", 32'(bus.parity_err), 32'h1);
`endif

        chk("single_pulse", 32'(dbl), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
